period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter.sv | 139 +++++++++++++
 tb/tb_period_meter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// period_meter: measures rising-to-rising period and high time of an asynchronous
// input, in clk cycles, after a SYNC_STAGES-deep synchroniser.
// Latency: meas_valid asserts SYNC_STAGES+1 clk edges after sig_in rises.
// Backpressure: none; meas_valid is a one-cycle pulse that must be consumed when it occurs.
// Ports:
//   clk, rst          - single clock, asynchronous active-high reset
//   sig_in            - measured signal, asynchronous to clk
//   period, high_time - last captured interval / high time, held between captures
//   meas_valid        - one-cycle pulse when a new period/high_time pair is captured
//   timeout           - sticky; set when no rising edge arrives within TIMEOUT cycles,
//                       cleared by the next rising edge
module period_meter #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = (2 ** WIDTH) - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout
);

    localparam logic [WIDTH-1:0] TO_V    = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic                   fall;
    logic [WIDTH-1:0]       cnt, cnt_nx;
    logic [WIDTH-1:0]       hcnt, hcnt_nx;
    logic                   hfell, hfell_nx;
    logic [WIDTH-1:0]       period_nx;
    logic [WIDTH-1:0]       high_nx;
    logic                   valid_nx;
    logic                   timeout_nx;

    // Synchroniser and edge register; nothing downstream looks at raw sig_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            s_d  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sig_in};
            s_d  <= s;
        end
    end

    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            hcnt       <= '0;
            hfell      <= 1'b0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            hcnt       <= hcnt_nx;
            hfell      <= hfell_nx;
            period     <= period_nx;
            high_time  <= high_nx;
            meas_valid <= valid_nx;
            timeout    <= timeout_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        hcnt_nx    = hcnt;
        hfell_nx   = hfell;
        period_nx  = period;
        high_nx    = high_time;
        valid_nx   = 1'b0;
        timeout_nx = timeout;
        case (state)
            IDLE: begin
                // First edge only arms the counters; there is no previous
                // rise to measure from, so no capture is made.
                if (rise) begin
                    cnt_nx     = ONE;
                    hcnt_nx    = ONE;
                    hfell_nx   = 1'b0;
                    timeout_nx = 1'b0;
                    state_nx   = MEASURE;
                end
            end
            MEASURE: begin
                // A rise on the same cycle cnt hits TIMEOUT is still a valid
                // measurement, so the rise is tested before the limit.
                if (rise) begin
                    period_nx = cnt;
                    high_nx   = hcnt;
                    valid_nx  = 1'b1;
                    cnt_nx    = ONE;
                    hcnt_nx   = ONE;
                    hfell_nx  = 1'b0;
                end else if (cnt >= TO_V) begin
                    timeout_nx = 1'b1;
                    state_nx   = IDLE;
                    cnt_nx     = '0;
                    hcnt_nx    = '0;
                    hfell_nx   = 1'b0;
                end else begin
                    cnt_nx = (cnt == CNT_MAX) ? cnt : cnt + ONE;
                    // High time stops at the first fall after the rise.
                    if (fall) begin
                        hfell_nx = 1'b1;
                    end else if (s && !hfell) begin
                        hcnt_nx = (hcnt == CNT_MAX) ? hcnt : hcnt + ONE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_period_meter.sv
module tb_period_meter;

    logic        clk;
    logic        rst;
    logic        sig_in;
    logic [15:0] period;
    logic [15:0] high_time;
    logic        meas_valid;
    logic        timeout;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    period_meter #(
        .WIDTH(16),
        .SYNC_STAGES(2),
        .TIMEOUT(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sig_in(sig_in),
        .period(period),
        .high_time(high_time),
        .meas_valid(meas_valid),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int t, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s (t=%0d): observed %0d expected %0d", tag, t, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sig_in = 1'b0;
        rst    = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag, input int t);
        chk({tag, "_period"}, t, 32'(period), 0);
        chk({tag, "_high"}, t, 32'(high_time), 0);
        chk({tag, "_valid"}, t, 32'(meas_valid), 0);
        chk({tag, "_timeout"}, t, 32'(timeout), 0);
    endtask

    initial begin
        rst    = 1'b1;
        sig_in = 1'b0;

        // Reset held for 13 ns; outputs checked after the first clock edge.
        #8;
        chk_all_zero("reset", 0);
        #5;
        rst = 1'b0;
        tick();

        // Divide-by-2: rise set on iteration r is visible 3 edges later.
        for (int t = 0; t <= 14; t++) begin
            sig_in = (t % 2 == 0);
            tick();
            chk("div2_valid", t, 32'(meas_valid), (t >= 4 && t % 2 == 0) ? 1 : 0);
            chk("div2_period", t, 32'(period), (t >= 4) ? 2 : 0);
            chk("div2_high", t, 32'(high_time), (t >= 4) ? 1 : 0);
        end

        // 7 high / 3 low: period 10, high 7, captures held between pulses.
        do_reset();
        for (int t = 0; t <= 35; t++) begin
            sig_in = ((t % 10) < 7);
            tick();
            chk("p10_valid", t, 32'(meas_valid), (t == 12 || t == 22 || t == 32) ? 1 : 0);
            chk("p10_period", t, 32'(period), (t >= 12) ? 10 : 0);
            chk("p10_high", t, 32'(high_time), (t >= 12) ? 7 : 0);
        end

        // One measurement (period 5, high 2), 60 cycles low, then rises at 67 and 73.
        do_reset();
        for (int t = 0; t <= 85; t++) begin
            sig_in = (t == 0 || t == 1 || t == 5 || t == 6 ||
                      t == 67 || t == 68 || t == 73 || t == 74);
            tick();
            chk("to_valid", t, 32'(meas_valid), (t == 7 || t == 75) ? 1 : 0);
            chk("to_flag", t, 32'(timeout), (t >= 57 && t < 69) ? 1 : 0);
            chk("to_period", t, 32'(period), (t < 7) ? 0 : ((t < 75) ? 5 : 6));
            chk("to_high", t, 32'(high_time), (t >= 7) ? 2 : 0);
        end

        // Rise exactly when cnt reaches TIMEOUT: captured as period 50, no timeout.
        do_reset();
        for (int t = 0; t <= 56; t++) begin
            sig_in = (t == 0 || t == 50);
            tick();
            chk("edge_to_valid", t, 32'(meas_valid), (t == 52) ? 1 : 0);
            chk("edge_to_flag", t, 32'(timeout), 0);
            if (t == 52) begin
                chk("edge_to_period", t, 32'(period), 50);
                chk("edge_to_high", t, 32'(high_time), 1);
            end
        end

        // Reset mid-measurement.
        do_reset();
        for (int t = 0; t <= 8; t++) begin
            sig_in = ((t % 4) < 2);
            tick();
            chk("mid_valid", t, 32'(meas_valid), (t == 6) ? 1 : 0);
            chk("mid_period", t, 32'(period), (t >= 6) ? 4 : 0);
        end
        rst = 1'b1;
        #1;
        chk_all_zero("mid_rst", 0);
        sig_in = 1'b0;
        tick();
        chk_all_zero("mid_rst", 1);
        tick();
        rst = 1'b0;
        for (int t = 0; t <= 12; t++) begin
            sig_in = ((t % 4) < 2);
            tick();
            chk("post_valid", t, 32'(meas_valid), (t == 6 || t == 10) ? 1 : 0);
            chk("post_period", t, 32'(period), (t >= 6) ? 4 : 0);
            chk("post_high", t, 32'(high_time), (t >= 6) ? 2 : 0);
        end

        // Stuck high from reset release: first rise arms, timeout 50 cycles later.
        do_reset();
        sig_in = 1'b1;
        for (int t = 0; t <= 60; t++) begin
            tick();
            chk("stuck_flag", t, 32'(timeout), (t >= 52) ? 1 : 0);
            chk("stuck_valid", t, 32'(meas_valid), 0);
            chk("stuck_period", t, 32'(period), 0);
            chk("stuck_high", t, 32'(high_time), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
